// File: rtl/mem_bus_initiator_pkg.sv
// rtl/mem_bus_initiator_pkg.sv - shared state encoding and command entry layout
package mem_bus_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int ENTRY_W = 65;

    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [31:0] data;
    } cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// rtl/mem_cmd_fifo.sv - synchronous command FIFO, head always visible on dout
module mem_cmd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Top pointer bit differs only when the writer has lapped the reader.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_bus_initiator.sv
// rtl/mem_bus_initiator.sv - queued single-outstanding memory bus master with response timeout
module mem_bus_initiator #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_BITS   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_write_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_read_data,
    output logic        rsp_error,
    output logic        memory_read,
    output logic        memory_write,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    input  logic        response,
    output logic        busy
);
    import mem_bus_initiator_pkg::*;

    localparam logic [TIMEOUT_BITS-1:0] COUNT_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_BITS-1:0] COUNT_ONE  = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  next_state;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    cmd_t                    fifo_din;
    cmd_t                    fifo_dout;
    cmd_t                    req;
    logic [TIMEOUT_BITS-1:0] count;

    assign fifo_din = '{write: cmd_write, address: cmd_address, data: cmd_write_data};

    mem_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid && !fifo_full),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ST_BUS;
                end
            end
            ST_BUS: begin
                if (response || count == COUNT_LAST) next_state = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) next_state = ST_GAP;
            end
            ST_GAP:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // A response in the final timeout cycle is checked first, so it wins over the error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req           <= '0;
            count         <= '0;
            rsp_write     <= 1'b0;
            rsp_read_data <= '0;
            rsp_error     <= 1'b0;
        end else begin
            if (pop) req <= fifo_dout;
            case (state)
                ST_BUS: begin
                    count <= count + COUNT_ONE;
                    if (response) begin
                        rsp_write     <= req.write;
                        rsp_read_data <= req.write ? '0 : read_data;
                        rsp_error     <= 1'b0;
                    end else if (count == COUNT_LAST) begin
                        rsp_write     <= req.write;
                        rsp_read_data <= '0;
                        rsp_error     <= 1'b1;
                    end
                end
                ST_GAP:  count <= '0;
                default: ;
            endcase
        end
    end

    assign cmd_ready    = !fifo_full;
    assign rsp_valid    = (state == ST_RSP);
    assign memory_read  = (state == ST_BUS) && !req.write;
    assign memory_write = (state == ST_BUS) && req.write;
    assign address      = req.address;
    assign write_data   = req.data;
    assign busy         = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb/tb_mem_bus_initiator.sv - randomized and directed bench with memory model and scoreboard
module tb_mem_bus_initiator;
    localparam int TO_CYC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_address;
    logic [31:0] cmd_write_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_read_data;
    logic        rsp_error;
    logic        memory_read;
    logic        memory_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        response;
    logic        busy;
    logic        mem_en;

    int total = 0;
    int bad   = 0;

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; int lat; } bus_t;
    typedef struct { logic w; logic [31:0] d; logic e; } res_t;

    bus_t        bus_q[$];
    int          lat_q[$];
    res_t        res_q[$];
    logic [31:0] mem_img [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    mem_bus_initiator #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TO_CYC),
        .TIMEOUT_BITS   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_address    (cmd_address),
        .cmd_write_data (cmd_write_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_write      (rsp_write),
        .rsp_read_data  (rsp_read_data),
        .rsp_error      (rsp_error),
        .memory_read    (memory_read),
        .memory_write   (memory_write),
        .address        (address),
        .write_data     (write_data),
        .read_data      (read_data),
        .response       (response),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference: commands complete strictly in order; a timed-out write never lands.
    function automatic void model_push(input logic w, input logic [31:0] a, input logic [31:0] d, input int lat);
        bus_t b;
        res_t r;
        logic to;
        to = (lat == 0) || (lat > TO_CYC);
        b.w = w; b.a = a; b.d = d; b.lat = lat;
        bus_q.push_back(b);
        lat_q.push_back(lat);
        r.w = w;
        r.e = to;
        if (to)     r.d = 32'h0;
        else if (w) begin r.d = 32'h0; ref_mem[a] = d; end
        else        r.d = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
        res_q.push_back(r);
    endfunction

    // Memory: responds on the lat-th strobe cycle; lat==0 means never.
    initial begin
        int cnt;
        int lat;
        cnt = 0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (!mem_en) begin
                cnt = 0;
                continue;
            end
            read_data = mem_img.exists(address) ? mem_img[address] : mem_init(address);
            if (reset || !(memory_read || memory_write)) begin
                cnt      = 0;
                response = 1'b0;
            end else begin
                if (cnt == 0) lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
                cnt++;
                response = (lat != 0) && (cnt == lat);
                if (response && memory_write) mem_img[address] = write_data;
            end
        end
    end

    // Bus and result monitor.
    initial begin
        logic        prev;
        logic        s;
        logic        stable;
        int          run;
        int          gap;
        int          exp_len;
        logic [31:0] a0;
        logic [31:0] d0;
        bus_t        cur;
        res_t        r;
        prev = 1'b0; run = 0; gap = 100; stable = 1'b1; a0 = '0; d0 = '0;
        cur.w = 1'b0; cur.a = '0; cur.d = '0; cur.lat = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev = 1'b0; run = 0; gap = 100;
                continue;
            end
            s = memory_read || memory_write;
            if (s && !prev) begin
                check("strobe_gap_ge3", 32'(gap >= 3), 1);
                check("single_strobe", 32'(memory_read && memory_write), 0);
                if (bus_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    cur = bus_q.pop_front();
                    check("bus_write", 32'(memory_write), 32'(cur.w));
                    check("bus_address", address, cur.a);
                    if (cur.w) check("bus_wdata", write_data, cur.d);
                end
                run = 1; stable = 1'b1; a0 = address; d0 = write_data;
            end else if (s) begin
                run++;
                if (address !== a0 || write_data !== d0 || memory_write !== cur.w) stable = 1'b0;
            end else if (prev) begin
                exp_len = (cur.lat == 0 || cur.lat > TO_CYC) ? TO_CYC : cur.lat;
                check("strobe_len", run, exp_len);
                check("bus_stable", 32'(stable), 1);
                gap = 1;
            end else begin
                gap++;
            end
            if (rsp_valid && rsp_ready) begin
                if (res_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    check("rsp_write", 32'(rsp_write), 32'(r.w));
                    check("rsp_read_data", rsp_read_data, r.d);
                    check("rsp_error", 32'(rsp_error), 32'(r.e));
                end
            end
            prev = s;
        end
    end

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input int lat);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_wait", 32'(n < 200), 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_write_data = d;
        model_push(w, a, d, lat);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while ((res_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 1);
    endtask

    initial begin
        int acc;
        logic last_rdy;
        reset = 1'b1; mem_en = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_address = '0; cmd_write_data = '0; rsp_ready = 1'b0;
        response = 1'b0; read_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_strobes", 32'(memory_read || memory_write), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_address", address, 0);
        check("rst_rsp_data", rsp_read_data, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single read with latency checks.
        mem_img[32'h10] = 32'hCAFE_BABE;
        ref_mem[32'h10] = 32'hCAFE_BABE;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'h10; cmd_write_data = '0;
        check("rd_cmd_ready", 32'(cmd_ready), 1);
        model_push(1'b0, 32'h10, 32'h0, 3);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("lat_t1_no_strobe", 32'(memory_read), 0);
        check("lat_t1_busy", 32'(busy), 1);
        @(negedge clk);
        check("lat_t2_strobe", 32'(memory_read), 1);
        check("lat_t2_addr", address, 32'h10);
        repeat (3) @(negedge clk);
        check("rd_rsp_valid", 32'(rsp_valid), 1);
        check("rd_data", rsp_read_data, 32'hCAFE_BABE);
        check("rd_error", 32'(rsp_error), 0);
        check("rd_write", 32'(rsp_write), 0);
        wait_drain(50);

        // Single write.
        rsp_ready = 1'b0;
        send_cmd(1'b1, 32'h20, 32'hA5A5_A5A5, 4);
        repeat (6) @(negedge clk);
        check("wr_rsp_valid", 32'(rsp_valid), 1);
        check("wr_write", 32'(rsp_write), 1);
        check("wr_data_zero", rsp_read_data, 0);
        wait_drain(50);

        // Queue full: five taken, sixth blocked.
        rsp_ready = 1'b0;
        acc = 0;
        last_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd_write = i[0]; cmd_address = 32'h200 + 32'(4 * i);
            cmd_write_data = $urandom;
            last_rdy = cmd_ready;
            if (cmd_ready) begin
                model_push(cmd_write, cmd_address, cmd_write_data, 2);
                acc++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("full_accepted", acc, 5);
        check("full_sixth_blocked", 32'(last_rdy), 0);
        repeat (4) @(negedge clk);
        check("full_stalled_ready", 32'(cmd_ready), 0);
        wait_drain(200);

        // Timeout, then a normal command; boundary at exactly TO_CYC.
        send_cmd(1'b0, 32'h30, 32'h0, 0);
        send_cmd(1'b0, 32'h34, 32'h0, 2);
        send_cmd(1'b0, 32'h38, 32'h0, TO_CYC);
        send_cmd(1'b1, 32'h3C, 32'h1234_5678, TO_CYC + 1);
        send_cmd(1'b0, 32'h3C, 32'h0, 1);
        wait_drain(200);

        // Stray response while idle.
        mem_en = 1'b0;
        @(negedge clk);
        response = 1'b1;
        @(negedge clk);
        response = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_rsp_valid", 32'(rsp_valid), 0);
            check("stray_busy", 32'(busy), 0);
        end
        mem_en = 1'b1;

        // Reset in the middle of a read strobe with two entries queued.
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_cmd(1'b0, 32'h40 + 32'(4 * i), 32'h0, 0);
        check("rstmid_strobe_on", 32'(memory_read), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstmid_strobe_drop", 32'(memory_read || memory_write), 0);
        bus_q.delete();
        lat_q.delete();
        res_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rstmid_busy", 32'(busy), 0);
            check("rstmid_cmd_ready", 32'(cmd_ready), 1);
            check("rstmid_rsp_valid", 32'(rsp_valid), 0);
        end
        send_cmd(1'b1, 32'h44, 32'h0BAD_F00D, 3);
        send_cmd(1'b0, 32'h44, 32'h0, 1);
        wait_drain(100);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            int r;
            int lat;
            r = $urandom_range(0, 19);
            lat = (r == 0) ? 0 : (r == 1) ? $urandom_range(TO_CYC + 1, TO_CYC + 4) : $urandom_range(1, TO_CYC);
            rsp_ready      = ($urandom_range(0, 9) < 7);
            cmd_valid      = ($urandom_range(0, 2) != 0);
            cmd_write      = $urandom_range(0, 1);
            cmd_address    = 32'h100 + 32'(4 * $urandom_range(0, 7));
            cmd_write_data = $urandom;
            if (cmd_valid && cmd_ready) model_push(cmd_write, cmd_address, cmd_write_data, lat);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_drain(3000);
        check("final_busy", 32'(busy), 0);
        check("final_bus_q", bus_q.size(), 0);
        check("final_res_q", res_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Core-side master for the controller's memory ports: core_read_memory, core_write_memory, core_address_memory, core_write_data_memory, core_read_data_memory and core_memory_response.
- Accepts queued read/write commands on a valid/ready interface and drives one bus transaction at a time.
- Waits for the memory response, with a timeout, and returns read data and status on a valid/ready result interface.
- Used as a bus-functional core stand-in for controller bring-up and as the bus front end of simple cores.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 1024, maximum cycles a strobe is held waiting for a response; minimum 2.
- TIMEOUT_BITS, 11, width of the timeout counter; must satisfy 2^TIMEOUT_BITS > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  queue can accept a command; equals !fifo_full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  32  byte address.
- cmd_write_data  in  32  write data; ignored for reads.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  result consumer ready.
- rsp_write  out  1  echoes the command type.
- rsp_read_data  out  32  captured read data; 0 for writes and on timeout.
- rsp_error  out  1  transaction timed out.
- memory_read  out  1  read strobe; connects to core_read_memory.
- memory_write  out  1  write strobe; connects to core_write_memory.
- address  out  32  connects to core_address_memory.
- write_data  out  32  connects to core_write_data_memory.
- read_data  in  32  connects to core_read_data_memory.
- response  in  1  connects to core_memory_response.
- busy  out  1  high when the FSM is not IDLE or the queue is non-empty.

Behaviour:
- Reset (asynchronous): all outputs 0 except cmd_ready=1; FIFO emptied; FSM goes to IDLE; the timeout counter clears. Strobes drop immediately, including mid-transaction. A pending response after reset is ignored.
- Queue push: on cmd_valid && cmd_ready, {cmd_write, cmd_address, cmd_write_data} is pushed.
  - When full, cmd_ready=0 and the command is not taken, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle with the queue neither full nor empty changes nothing in the count.
- FSM states: IDLE, BUS, RSP, GAP.
- IDLE: if the FIFO is non-empty, pop the head into the request registers and go to BUS. Strobes are low.
- BUS:
  - Drive address and write_data from the request registers, and exactly one of memory_read/memory_write. Values are held stable for the whole state.
  - The counter increments every cycle.
  - If response=1: capture read_data (reads only; writes capture 0), set rsp_error=0, go to RSP.
  - Else if counter == TIMEOUT_CYCLES-1: set rsp_error=1 and rsp_read_data=0, go to RSP.
  - A response arriving in the same cycle the timeout is reached wins; no error is flagged.
- RSP:
  - Strobes low; rsp_valid=1; rsp_write, rsp_read_data and rsp_error are held.
  - On rsp_ready, deassert rsp_valid next cycle and go to GAP.
  - There is no limit on stall length.
- GAP: one cycle with strobes low (guaranteed strobe gap between transactions), counter cleared, then IDLE.
- Latency:
  - A command accepted at cycle t into an empty, idle block pops at t+1; the strobe is high from t+2.
  - A response sampled at cycle n gives rsp_valid=1 from n+1.
  - With rsp_ready held high, back-to-back commands have their strobes separated by 3 low cycles (RSP, GAP, IDLE).
- response while in IDLE, RSP or GAP is ignored.
- address and write_data keep their last value outside BUS.

Decomposition:
- Shared package: FSM state encoding (2 bits: IDLE=0, BUS=1, RSP=2, GAP=3) and the FIFO entry width constant (65).
- One sub-module: mem_cmd_fifo, a synchronous FIFO with parameters WIDTH and DEPTH.
  - Interface: push, pop, full, empty, din, dout.
  - Head is always visible on dout; read pointers wrap modulo DEPTH.
  - An extra pointer bit distinguishes full from empty.

Test Plan:
- Single read: read cmd to 0x00000010; memory responds 3 cycles after the strobe with 0xCAFEBABE -> memory_read high 3 cycles with address=0x10 -> rsp_valid, rsp_read_data=0xCAFEBABE, rsp_error=0, rsp_write=0.
- Single write: 0xA5A5A5A5 to 0x00000020 -> memory_write high until response, write_data stable for the whole strobe -> rsp_write=1, rsp_read_data=0.
- Queue full: 5 commands pushed back-to-back with rsp_ready=0, FIFO_DEPTH=4 -> 4 accepted plus 1 popped into BUS; the 6th blocked with cmd_ready=0; all complete in push order.
- Timeout: TIMEOUT_CYCLES=8, response tied 0 -> strobe high exactly 8 cycles -> rsp_error=1, rsp_read_data=0; the next command proceeds normally.
- Boundary: response arrives on the 8th strobe cycle (TIMEOUT_CYCLES=8) -> rsp_error=0 and data captured. Stray response pulse while IDLE -> no rsp_valid.
- Reset mid-BUS: assert reset during a read strobe with 2 entries queued -> strobes drop the same cycle; after release busy=0, cmd_ready=1, no rsp_valid.
